// File: rtl/uart_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_pkg
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// default burst and idle-timeout limits, and a helper that sizes index
// fields so a single-requester build still gets a 1-bit index.
// ---------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

    typedef logic [0:0] arb_state_t;

    localparam arb_state_t ST_IDLE   = 1'b0;
    localparam arb_state_t ST_LOCKED = 1'b1;

    localparam int DEFAULT_MAX_BURST    = 16;
    localparam int DEFAULT_IDLE_TIMEOUT = 255;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin search. Starting one past last_grant and
// wrapping modulo N_REQ, returns the first requester whose valid bit is set.
//
// Ports
//   valid       in   N_REQ   request vector
//   last_grant  in   IDX_W   requester that was served most recently
//   found       out  1       at least one request is pending
//   index       out  IDX_W   winning requester (0 when nothing is found)
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] last_grant,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    // Walk the candidates from farthest to nearest so that the nearest
    // requester after last_grant is written last and therefore wins,
    // which keeps the loop free of early exits.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        found    = 1'b0;
        index    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand     = (int'(last_grant) + k) % N_REQ;
            cand_idx = IDX_W'(cand);
            if (valid[cand_idx]) begin
                found = 1'b1;
                index = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmit byte channel between N_REQ requesters. A grant is
// held for a whole message and released on the last byte, after MAX_BURST
// bytes, or after IDLE_TIMEOUT consecutive cycles in which the grantee offers
// nothing (the latter also raises a sticky per-requester timeout flag).
//
// Ports
//   clock         in   1             rising-edge clock
//   reset         in   1             synchronous, active-high reset
//   req_valid     in   N_REQ         per-requester byte offered
//   req_data      in   8*N_REQ       per-requester byte, requester i at [8i+7:8i]
//   req_last      in   N_REQ         offered byte ends its message
//   req_ready     out  N_REQ         byte accepted (with req_valid)
//   tx_valid      out  1             byte presented to the transmitter
//   tx_data       out  8             byte to transmit
//   tx_ready      in   1             transmitter accepts the byte
//   busy          out  1             a grant is held
//   grant_id      out  IDX_W         current or most recent grantee
//   timeout_flag  out  N_REQ         sticky "released by timeout" flags
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int MAX_BURST    = DEFAULT_MAX_BURST,
    parameter int IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT,
    localparam int IDX_W       = idx_width(N_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic               tx_valid,
    output logic [7:0]         tx_data,
    input  logic               tx_ready,
    output logic               busy,
    output logic [IDX_W-1:0]   grant_id,
    output logic [N_REQ-1:0]   timeout_flag
);

    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    arb_state_t        state;
    logic [IDX_W-1:0]  last_grant;
    logic [4:0]        burst_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [IDLE_W-1:0] idle_next;

    logic              locked;
    logic              sel_valid;
    logic              sel_last;
    logic [7:0]        sel_data;
    logic              transfer;
    logic              end_of_grant;
    logic              timeout_hit;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_index;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .valid      (req_valid),
        .last_grant (last_grant),
        .found      (pick_found),
        .index      (pick_index)
    );

    assign locked    = (state == ST_LOCKED);
    assign sel_valid = req_valid[grant_id];
    assign sel_last  = req_last[grant_id];
    assign sel_data  = req_data[{grant_id, 3'b000} +: 8];

    // Handshake outputs are masked during the reset cycle so a message being
    // abandoned by reset cannot slip one more byte through.
    assign transfer  = locked & sel_valid & tx_ready & ~reset;
    assign tx_valid  = locked & sel_valid & ~reset;
    assign tx_data   = locked ? sel_data : 8'h00;
    assign busy      = locked;

    // Only the grantee ever sees ready, so at most one bit is set.
    always_comb begin
        req_ready = '0;
        if (locked && !reset) begin
            req_ready[grant_id] = tx_ready;
        end
    end

    // A byte that moves ends the grant if it is the last of its message or
    // the final byte allowed by the burst limit; both together still mean a
    // single release.
    assign end_of_grant = transfer & (sel_last | (burst_cnt == 5'(MAX_BURST - 1)));

    // The timeout only fires on a cycle where the grantee offers nothing, so
    // a transfer can never coincide with it and no flag is raised then.
    assign idle_next   = idle_cnt + IDLE_W'(1);
    assign timeout_hit = locked & ~sel_valid & (idle_next == IDLE_W'(IDLE_TIMEOUT));

    // Main arbiter state. last_grant starts at the top index so requester 0
    // wins the first arbitration after reset, and the released grantee always
    // becomes lowest priority for the next search.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            grant_id     <= '0;
            last_grant   <= IDX_W'(N_REQ - 1);
            burst_cnt    <= '0;
            idle_cnt     <= '0;
            timeout_flag <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_id  <= pick_index;
                        state     <= ST_LOCKED;
                        burst_cnt <= '0;
                        idle_cnt  <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (transfer) begin
                        burst_cnt <= burst_cnt + 5'd1;
                    end
                    if (sel_valid) begin
                        idle_cnt <= '0;
                    end else begin
                        idle_cnt <= idle_next;
                    end
                    if (end_of_grant) begin
                        state      <= ST_IDLE;
                        last_grant <= grant_id;
                    end else if (timeout_hit) begin
                        state                  <= ST_IDLE;
                        last_grant             <= grant_id;
                        timeout_flag[grant_id] <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the UART transmit byte channel.
REQ-002 Parameter MAX_BURST, default 16, maximum bytes per grant before a forced release.
REQ-003 Parameter IDLE_TIMEOUT, default 255, number of consecutive cycles without req_valid before a stalled grant is released.
REQ-004 clock  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  N_REQ  per-requester byte offered.
REQ-007 req_data  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-008 req_last  input  N_REQ  marks the offered byte as the final byte of a message.
REQ-009 req_ready  output  N_REQ  per-requester byte accepted this cycle when ANDed with req_valid.
REQ-010 tx_valid  output  1  byte presented to the UART transmitter.
REQ-011 tx_data  output  8  byte to transmit.
REQ-012 tx_ready  input  1  transmitter accepts the byte when tx_valid and tx_ready are both high.
REQ-013 busy  output  1  high while a grant is held.
REQ-014 grant_id  output  $clog2(N_REQ)  index of the current or most recent grantee.
REQ-015 timeout_flag  output  N_REQ  sticky per-requester flag, set when that requester's grant is released by timeout.

Function
REQ-016 The FSM SHALL have two states, IDLE and LOCKED.
REQ-017 In IDLE, busy, tx_valid and all req_ready bits SHALL be 0.
REQ-018 In IDLE, when any req_valid is high, the arbiter SHALL pick the first requester with req_valid high, searching round-robin from last_grant+1 (mod N_REQ).
REQ-019 On that pick, the arbiter SHALL register the winner into grant_id and enter LOCKED on the next edge; grant latency is 1 cycle.
REQ-020 In LOCKED, tx_valid, tx_data and req_last SHALL pass combinationally from requester grant_id.
REQ-021 In LOCKED, req_ready[grant_id] SHALL equal tx_ready, and all other req_ready bits SHALL be 0.
REQ-022 A transfer is defined as tx_valid & tx_ready; each transfer SHALL increment the 5-bit burst_cnt, which SHALL clear on entry to LOCKED.
REQ-023 On a transfer with req_last=1, the FSM SHALL return to IDLE at the next edge.
REQ-024 On a transfer with burst_cnt==MAX_BURST-1, the FSM SHALL return to IDLE at the next edge (forced release).
REQ-025 On any return to IDLE, last_grant SHALL be set to grant_id, so the released requester has lowest priority in the next arbitration.
REQ-026 In LOCKED, idle_cnt SHALL count consecutive cycles with req_valid[grant_id]=0, clearing whenever req_valid[grant_id] is high.
REQ-027 When idle_cnt reaches IDLE_TIMEOUT, the FSM SHALL return to IDLE and set timeout_flag[grant_id].
REQ-028 Simultaneous last-byte transfer and burst limit SHALL cause a single release and no timeout flag.
REQ-029 A transfer in the same cycle as a timeout SHALL take priority: the flag SHALL NOT be set.
REQ-030 A requester dropping req_valid mid-message SHALL keep the grant until req_last, the burst limit, or the timeout releases it.
REQ-031 timeout_flag bits SHALL clear only on reset.
REQ-032 The arbiter SHALL never assert more than one req_ready bit in any cycle.
REQ-033 The IDLE-to-LOCKED arbitration cycle SHALL NOT transfer any byte, including from the winner.

Reset
REQ-034 On reset, the FSM SHALL be IDLE, with busy=0, tx_valid=0, req_ready=0, grant_id=0, last_grant=N_REQ-1 (so requester 0 wins first), burst_cnt=0, idle_cnt=0 and timeout_flag=0.
REQ-035 Reset asserted mid-LOCKED SHALL abandon the message without completing it; no ready SHALL be asserted in the reset cycle.

Structure
REQ-036 The FSM state encoding and the default values of MAX_BURST and IDLE_TIMEOUT SHALL live in the shared UART package.
REQ-037 The round-robin search SHALL be one sub-module, rr_picker: a purely combinational function of (valid vector, last_grant) returning a found flag and an index.

Verification
REQ-038 Reset, then only req_valid[2]=1 with a 3-byte message 0x41,0x42,0x43 (last on 0x43), tx_ready=1 -> grant_id=2 one cycle after the request; tx_data sequence 0x41,0x42,0x43; busy drops the cycle after 0x43.
REQ-039 All four requesters valid continuously with one-byte messages (last=1) -> grant order 0,1,2,3,0 with no requester granted twice in a row.
REQ-040 Requester 1 streams 20 bytes with no req_last, MAX_BURST=16 -> release after the 16th transfer; requester 1 is regranted only after the other pending requesters are served.
REQ-041 Requester 3 granted, sends 1 byte, then drops req_valid for 255 cycles -> release; timeout_flag=4'b1000; flag persists until reset.
REQ-042 tx_ready held low for 10 cycles while requester 0 is locked -> tx_data stable, req_ready[0]=0, burst_cnt unchanged, no timeout (req_valid is high).
REQ-043 Reset pulsed mid-message -> next cycle IDLE with all outputs 0; the next arbitration favours requester 0.
